// File: rtl/small_fifo_pkg.sv
// Shared constants and types for the depth-1/depth-2 small FIFO.
package small_fifo_pkg;
  localparam int SMALL_FIFO_DEPTH_MIN = 1;
  localparam int SMALL_FIFO_DEPTH_MAX = 2;

  typedef logic [1:0] cnt_t;
endpackage

// File: rtl/small_fifo_if.sv
// Enqueue/dequeue handshake bundle for small_fifo.
interface small_fifo_if #(parameter int width = 8);
  logic [width-1:0] D_IN;
  logic             ENQ;
  logic             DEQ;
  logic             CLR;
  logic [width-1:0] D_OUT;
  logic             FULL_N;
  logic             EMPTY_N;

  modport master (output D_IN, ENQ, DEQ, CLR, input D_OUT, FULL_N, EMPTY_N);
  modport slave  (input D_IN, ENQ, DEQ, CLR, output D_OUT, FULL_N, EMPTY_N);
endinterface

// File: rtl/small_fifo_ctrl.sv
// Occupancy count, registered flags and data-register load enables.
module small_fifo_ctrl
  import small_fifo_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic enq,
  input  logic deq,
  output logic full_n,
  output logic empty_n,
  output logic ld_head,
  output logic shift,
  output logic ld_tail
);
  localparam cnt_t DEPTH_C = cnt_t'(DEPTH);

  cnt_t cnt, cnt_nxt;
  logic enq_ok, deq_ok;

  // Gating on the registered flags makes DEPTH=1 enq/deq mutually exclusive.
  assign enq_ok = enq & full_n;
  assign deq_ok = deq & empty_n;

  always_comb begin
    cnt_nxt = cnt;
    if (enq_ok && !deq_ok)      cnt_nxt = cnt + 2'd1;
    else if (deq_ok && !enq_ok) cnt_nxt = cnt - 2'd1;
  end

  assign ld_head = enq_ok && ((cnt == 2'd0) || deq_ok);
  assign shift   = deq_ok && (cnt == 2'd2);
  assign ld_tail = (DEPTH == 2) && enq_ok && !deq_ok && (cnt == 2'd1);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt     <= '0;
      full_n  <= 1'b1;
      empty_n <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      full_n  <= (cnt_nxt != DEPTH_C);
      empty_n <= (cnt_nxt != 2'd0);
    end
  end
endmodule

// File: rtl/small_fifo.sv
// Depth-1/2 synchronous FIFO with registered head and flags, no bypass.
// Define SMALL_FIFO_ERROR_CHECK_EN for simulation-only misuse messages.
module small_fifo
  import small_fifo_pkg::*;
#(
  parameter int width = 8,
  parameter int DEPTH = 2
) (
  input  logic         CLK,
  input  logic         RST,
  small_fifo_if.slave  bus
);
  if (DEPTH < SMALL_FIFO_DEPTH_MIN || DEPTH > SMALL_FIFO_DEPTH_MAX) begin : g_bad_depth
    $error("small_fifo: DEPTH must be 1 or 2");
  end

  logic [width-1:0] data0, data1;
  logic ld_head, shift, ld_tail;

  small_fifo_ctrl #(.DEPTH(DEPTH)) u_ctrl (
    .clk     (CLK),
    .rst     (RST),
    .clr     (bus.CLR),
    .enq     (bus.ENQ),
    .deq     (bus.DEQ),
    .full_n  (bus.FULL_N),
    .empty_n (bus.EMPTY_N),
    .ld_head (ld_head),
    .shift   (shift),
    .ld_tail (ld_tail)
  );

  // data1 only ever loads when DEPTH=2; for DEPTH=1 it stays at zero.
  always_ff @(posedge CLK) begin
    if (RST || bus.CLR) begin
      data0 <= '0;
      data1 <= '0;
    end else begin
      if (ld_head)    data0 <= bus.D_IN;
      else if (shift) data0 <= data1;
      if (ld_tail)    data1 <= bus.D_IN;
    end
  end

  assign bus.D_OUT = data0;

`ifdef SMALL_FIFO_ERROR_CHECK_EN
  always @(posedge CLK) begin
    if (!RST && !bus.CLR) begin
      if (bus.ENQ && !bus.FULL_N && !(bus.DEQ && bus.EMPTY_N))
        $display("%m @%0t: small_fifo error: ENQ while full", $time);
      if (bus.DEQ && !bus.EMPTY_N)
        $display("%m @%0t: small_fifo error: DEQ while empty", $time);
    end
  end
`endif
endmodule

// File: tb/tb_small_fifo.sv
// Scoreboard bench: DEPTH=2 and DEPTH=1 instances share stimulus, each checked against a queue model.
module tb_small_fifo;
  typedef logic [7:0] byte_q_t[$];
  typedef struct packed {
    logic [7:0] d_out;
    logic       full_n;
    logic       empty_n;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  small_fifo_if #(.width(8)) f2 ();
  small_fifo_if #(.width(8)) f1 ();

  small_fifo #(.width(8), .DEPTH(2)) u_d2 (.CLK(clk), .RST(rst), .bus(f2));
  small_fifo #(.width(8), .DEPTH(1)) u_d1 (.CLK(clk), .RST(rst), .bus(f1));

  int checks = 0;
  int errors = 0;

  exp_t exp2[$];
  exp_t exp1[$];

  byte_q_t    q2, q1;
  logic [7:0] head2 = 8'h00, head1 = 8'h00;

  // Reference: a FIFO queue of at most dep words; head holds its last value once empty.
  task automatic model_step(input int dep, inout byte_q_t q, inout logic [7:0] head,
                            input logic r, input logic c, input logic e, input logic d,
                            input logic [7:0] din, output exp_t ex);
    bit do_enq, do_deq;
    if (r || c) begin
      q = {};
      head = 8'h00;
    end else begin
      do_enq = e && (q.size() < dep);
      do_deq = d && (q.size() > 0);
      if (do_deq) void'(q.pop_front());
      if (do_enq) q.push_back(din);
      if (q.size() > 0) head = q[0];
    end
    ex.d_out   = head;
    ex.full_n  = (q.size() < dep);
    ex.empty_n = (q.size() > 0);
  endtask

  task automatic step(input logic r, input logic c, input logic e, input logic d, input logic [7:0] din);
    exp_t ex;
    @(negedge clk);
    rst = r;
    f2.CLR = c; f2.ENQ = e; f2.DEQ = d; f2.D_IN = din;
    f1.CLR = c; f1.ENQ = e; f1.DEQ = d; f1.D_IN = din;
    @(posedge clk);
    model_step(2, q2, head2, r, c, e, d, din, ex); exp2.push_back(ex);
    model_step(1, q1, head1, r, c, e, d, din, ex); exp1.push_back(ex);
  endtask

  always @(negedge clk) begin
    exp_t ex;
    if (exp2.size() > 0) begin
      ex = exp2.pop_front();
      checks++;
      if ({f2.D_OUT, f2.FULL_N, f2.EMPTY_N} !== ex) begin
        errors++;
        $display("FAIL depth2 @%0t: got dout=%h full_n=%b empty_n=%b, want dout=%h full_n=%b empty_n=%b",
                 $time, f2.D_OUT, f2.FULL_N, f2.EMPTY_N, ex.d_out, ex.full_n, ex.empty_n);
      end
    end
    if (exp1.size() > 0) begin
      ex = exp1.pop_front();
      checks++;
      if ({f1.D_OUT, f1.FULL_N, f1.EMPTY_N} !== ex) begin
        errors++;
        $display("FAIL depth1 @%0t: got dout=%h full_n=%b empty_n=%b, want dout=%h full_n=%b empty_n=%b",
                 $time, f1.D_OUT, f1.FULL_N, f1.EMPTY_N, ex.d_out, ex.full_n, ex.empty_n);
      end
    end
  end

  initial begin
    f2.CLR = 1'b0; f2.ENQ = 1'b0; f2.DEQ = 1'b0; f2.D_IN = 8'h00;
    f1.CLR = 1'b0; f1.ENQ = 1'b0; f1.DEQ = 1'b0; f1.D_IN = 8'h00;

    step(1, 0, 0, 0, 8'h00);
    step(1, 0, 1, 1, 8'hFF);
    // back-to-back fill, ignored third enqueue, drain
    step(0, 0, 1, 0, 8'h11);
    step(0, 0, 1, 0, 8'h22);
    step(0, 0, 1, 0, 8'h33);
    step(0, 0, 0, 1, 8'h00);
    step(0, 0, 0, 1, 8'h00);
    step(0, 0, 0, 1, 8'h00);
    step(0, 0, 0, 0, 8'h00);
    // streaming
    step(0, 0, 1, 0, 8'h01);
    for (int i = 2; i <= 5; i++) step(0, 0, 1, 1, 8'(i));
    step(0, 0, 0, 1, 8'h00);
    step(0, 0, 0, 1, 8'h00);
    // single-entry pattern
    step(0, 0, 1, 0, 8'hA5);
    step(0, 0, 1, 0, 8'h5A);
    step(0, 0, 0, 1, 8'h00);
    step(0, 0, 1, 0, 8'h5A);
    step(0, 0, 0, 0, 8'h00);
    // clear beats a concurrent enqueue/dequeue
    step(0, 0, 1, 0, 8'h77);
    step(0, 0, 1, 0, 8'h88);
    step(0, 1, 1, 1, 8'h99);
    step(0, 0, 0, 0, 8'h00);
    step(0, 0, 0, 1, 8'h00);

    for (int i = 0; i < 3000; i++) begin
      logic r, c, e, d;
      r = ($urandom_range(0, 99) < 2);
      c = ($urandom_range(0, 99) < 3);
      e = ($urandom_range(0, 99) < 60);
      d = ($urandom_range(0, 99) < 55);
      step(r, c, e, d, 8'($urandom));
    end

    for (int i = 0; i < 10 && (exp2.size() > 0 || exp1.size() > 0); i++) @(posedge clk);
    @(negedge clk);
    #1;
    if (exp2.size() > 0 || exp1.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d/%0d expectations left, want 0", exp2.size(), exp1.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
